main_mem_hs: RTL

Parametrised byte-addressed main memory with a valid/ready request/response handshake. Supports configurable read/write latency and byte/half/word accesses with sign or zero extension. Detects misaligned and out-of-range accesses. Serves as the shared instruction/data memory model behind the fetch and load/store stages; it replaces the single-cycle, word-only memory.

---
 rtl/main_mem_pkg.sv | 31 +++
 rtl/main_mem_align.sv | 47 ++++
 rtl/main_mem_hs.sv | 134 +++++++++++++
 3 files changed

// File: rtl/main_mem_pkg.sv
// Shared encodings for the main memory handshake model.
package main_mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_ILL  = 2'b11;

    localparam logic READ  = 1'b0;
    localparam logic WRITE = 1'b1;

    localparam int unsigned LATENCY_MAX = 15;
    localparam int unsigned LAT_CNT_W   = $clog2(LATENCY_MAX + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // Number of bytes touched by an access of the given size.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SIZE_BYTE: size_bytes = 3'd1;
            SIZE_HALF: size_bytes = 3'd2;
            SIZE_WORD: size_bytes = 3'd4;
            default:   size_bytes = 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/main_mem_align.sv
// Byte-lane steering, read extension and alignment check for one access.
module main_mem_align
    import main_mem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  lane_en_c,
    output logic [31:0] wlane_c,
    output logic [31:0] rdata_c,
    output logic        misaligned_c
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    // Select lanes, replicate write data and extend read data by access size.
    always_comb begin
        lane_en_c    = 4'b0000;
        wlane_c      = wdata;
        rdata_c      = rword;
        misaligned_c = 1'b0;
        rbyte        = rword[{addr_lo, 3'b000} +: 8];
        rhalf        = addr_lo[1] ? rword[31:16] : rword[15:0];
        case (size)
            SIZE_BYTE: begin
                lane_en_c = 4'b0001 << addr_lo;
                wlane_c   = {4{wdata[7:0]}};
                rdata_c   = {{24{~is_unsigned & rbyte[7]}}, rbyte};
            end
            SIZE_HALF: begin
                lane_en_c    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wlane_c      = {2{wdata[15:0]}};
                rdata_c      = {{16{~is_unsigned & rhalf[15]}}, rhalf};
                misaligned_c = addr_lo[0];
            end
            SIZE_WORD: begin
                lane_en_c    = 4'b1111;
                misaligned_c = (addr_lo != 2'b00);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/main_mem_hs.sv
// Byte-addressed main memory with valid/ready request and response channels.
module main_mem_hs
    import main_mem_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'('h01000000),
    parameter int unsigned           DEPTH_BYTES = 'h0100000,
    parameter int unsigned           LATENCY     = 1,
    parameter string                 INIT_FILE   = ""
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_error
);

    localparam int unsigned           WORDS   = DEPTH_BYTES / 4;
    localparam int unsigned           IDX_W   = $clog2(WORDS);
    localparam logic [ADDR_WIDTH:0]   DEPTH_X = (ADDR_WIDTH + 1)'(DEPTH_BYTES);

    // Word-organised storage; preloading from INIT_FILE is left to the
    // simulation environment, which can address this array directly.
    logic [31:0] mem [WORDS];

    state_t                 state, state_n;
    logic [LAT_CNT_W-1:0]   cnt, cnt_n;

    logic                   accept;
    logic [ADDR_WIDTH-1:0]  offset;
    logic [ADDR_WIDTH:0]    offset_end;
    logic [IDX_W-1:0]       word_idx;
    logic                   out_of_range;
    logic                   acc_error;
    logic                   do_write;
    logic [31:0]            rword;
    logic [3:0]             lane_en;
    logic [31:0]            wlane;
    logic [31:0]            rdata_ext;
    logic                   misaligned;

    assign req_ready = (state == IDLE);
    assign accept    = (state == IDLE) && req_valid;

    // Offset kept at address width; addresses below base are flagged, not wrapped.
    assign offset       = req_addr - BASE_ADDR;
    assign offset_end   = {1'b0, offset} + (ADDR_WIDTH + 1)'(size_bytes(req_size));
    assign out_of_range = (req_addr < BASE_ADDR) || (offset_end > DEPTH_X);
    assign word_idx     = offset[IDX_W+1:2];
    assign rword        = mem[word_idx];
    assign acc_error    = misaligned || out_of_range || (req_size == SIZE_ILL);
    assign do_write     = accept && reset_n && (req_write == WRITE) && !acc_error;

    main_mem_align u_align (
        .addr_lo      (req_addr[1:0]),
        .size         (req_size),
        .is_unsigned  (req_unsigned),
        .wdata        (req_wdata),
        .rword        (rword),
        .lane_en_c    (lane_en),
        .wlane_c      (wlane),
        .rdata_c      (rdata_ext),
        .misaligned_c (misaligned)
    );

    // Commit legal writes on their accept edge, only in the addressed lanes.
    always_ff @(posedge clock) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) begin
                    mem[word_idx][8*i +: 8] <= wlane[8*i +: 8];
                end
            end
        end
    end

    // State, latency counter and registered response.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            rsp_valid <= (state_n == RESP);
            if (accept) begin
                rsp_error <= acc_error;
                rsp_rdata <= (!acc_error && req_write == READ) ? rdata_ext : 32'h0;
            end
        end
    end

    // Next state: IDLE accepts, BUSY counts down the latency, RESP waits for ready.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (LATENCY == 1) begin
                        state_n = RESP;
                    end else begin
                        state_n = BUSY;
                        cnt_n   = LAT_CNT_W'(LATENCY - 1);
                    end
                end
            end
            BUSY: begin
                cnt_n = cnt - LAT_CNT_W'(1);
                if (cnt == LAT_CNT_W'(1)) begin
                    state_n = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
